// File: rtl/bp_sac_edge_concentrator.sv
// bp_sac_edge_concentrator
//
// Wormhole-aware N:1 concentrator for the east edge of the streaming accelerator
// complex. Each row link feeds a 2-entry FIFO; a round-robin arbiter picks a row
// at packet granularity and holds it until the packet's last body flit has been
// forwarded.
//
// Optional feature macro: BP_SAC_EDGE_PERF_EN
//   defined   : per-input forwarded-flit counters and an output stall counter
//               (saturating, cleared on reset)
//   undefined : perf outputs tied to zero, no counter flops
//
// Ports
//   clk_i            clock
//   reset_i          synchronous active-high reset
//   in_data_i        row flits, row j at [j*flit_width_p +: flit_width_p]
//   in_v_i           per-row valid
//   in_ready_and_o   per-row ready (FIFO not full)
//   out_data_o       concentrated flit
//   out_v_o          output valid
//   out_ready_and_i  downstream ready
//   grant_o          one-hot owner row, zero when nothing is owned
//   busy_o           a packet is pending (header stalled) or mid-body
//   perf_flits_o     per-row forwarded flit count
//   perf_stall_o     cycles with out_v_o=1 and out_ready_and_i=0

module bp_sac_edge_concentrator #(
    parameter int unsigned num_in_p     = 4,
    parameter int unsigned flit_width_p = 64,
    parameter int unsigned len_width_p  = 4,
    parameter int unsigned len_offset_p = 0,
    parameter int unsigned perf_width_p = 32
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [num_in_p*flit_width_p-1:0]     in_data_i,
    input  logic [num_in_p-1:0]                  in_v_i,
    output logic [num_in_p-1:0]                  in_ready_and_o,
    output logic [flit_width_p-1:0]              out_data_o,
    output logic                                 out_v_o,
    input  logic                                 out_ready_and_i,
    output logic [num_in_p-1:0]                  grant_o,
    output logic                                 busy_o,
    output logic [num_in_p*perf_width_p-1:0]     perf_flits_o,
    output logic [perf_width_p-1:0]              perf_stall_o
);

    localparam int unsigned SelW = (num_in_p > 1) ? $clog2(num_in_p) : 1;

    typedef enum logic [1:0] {StIdle, StPend, StBody} state_e;

    // Input FIFOs
    logic [flit_width_p-1:0] mem_q [num_in_p][2];
    logic [1:0]              occ_q [num_in_p];
    logic [num_in_p-1:0]     rd_q, wr_q;
    logic [num_in_p-1:0]     head_v, enq, deq;
    logic [flit_width_p-1:0] head_data [num_in_p];

    // Arbitration / packet tracking
    state_e                  state_q;
    logic [SelW-1:0]         sel_q, ptr_q, arb_sel, cur_sel, ptr_nxt;
    logic [len_width_p-1:0]  cnt_q, hdr_len;
    logic                    arb_found, owned, out_hs;

    always_comb begin
        for (int j = 0; j < num_in_p; j++) begin
            head_v[j]         = (occ_q[j] != 2'd0);
            head_data[j]      = mem_q[j][rd_q[j]];
            in_ready_and_o[j] = (occ_q[j] != 2'd2) & ~reset_i;
            enq[j]            = in_v_i[j] & in_ready_and_o[j];
        end
    end

    // First row with a valid head at or after the pointer, in modulo order.
    always_comb begin
        logic [SelW-1:0] cand;
        arb_found = 1'b0;
        arb_sel   = '0;
        cand      = '0;
        for (int unsigned i = 0; i < num_in_p; i++) begin
            cand = SelW'((32'(ptr_q) + i) % num_in_p);
            if (!arb_found && head_v[cand]) begin
                arb_found = 1'b1;
                arb_sel   = cand;
            end
        end
    end

    always_comb begin
        cur_sel    = (state_q == StIdle) ? arb_sel : sel_q;
        owned      = (state_q == StIdle) ? arb_found : 1'b1;
        out_v_o    = ~reset_i & owned & head_v[cur_sel];
        out_data_o = head_data[cur_sel];
        out_hs     = out_v_o & out_ready_and_i;
        hdr_len    = out_data_o[len_offset_p +: len_width_p];
        busy_o     = ~reset_i & (state_q != StIdle);
        ptr_nxt    = (cur_sel == SelW'(num_in_p - 1)) ? '0 : cur_sel + SelW'(1);
        for (int j = 0; j < num_in_p; j++) begin
            grant_o[j] = ~reset_i & owned & (cur_sel == SelW'(j));
            deq[j]     = out_hs & (cur_sel == SelW'(j));
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            rd_q <= '0;
            wr_q <= '0;
            for (int j = 0; j < num_in_p; j++) occ_q[j] <= 2'd0;
        end else begin
            for (int j = 0; j < num_in_p; j++) begin
                if (enq[j]) wr_q[j] <= ~wr_q[j];
                if (deq[j]) rd_q[j] <= ~rd_q[j];
                occ_q[j] <= occ_q[j] + {1'b0, enq[j]} - {1'b0, deq[j]};
            end
        end
    end

    // Flit storage carries no reset; occupancy alone defines validity.
    always_ff @(posedge clk_i) begin
        for (int j = 0; j < num_in_p; j++) begin
            if (enq[j]) mem_q[j][wr_q[j]] <= in_data_i[j*flit_width_p +: flit_width_p];
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= StIdle;
            sel_q   <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                StIdle, StPend: begin
                    if (out_hs) begin
                        if (hdr_len == '0) begin
                            state_q <= StIdle;
                            ptr_q   <= ptr_nxt;
                        end else begin
                            state_q <= StBody;
                            cnt_q   <= hdr_len;
                            sel_q   <= cur_sel;
                        end
                    end else if (state_q == StIdle && arb_found) begin
                        // Header offered but not taken: lock the choice.
                        state_q <= StPend;
                        sel_q   <= arb_sel;
                    end
                end
                StBody: begin
                    if (out_hs) begin
                        if (cnt_q == len_width_p'(1)) begin
                            state_q <= StIdle;
                            ptr_q   <= ptr_nxt;
                        end
                        cnt_q <= cnt_q - len_width_p'(1);
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

`ifdef BP_SAC_EDGE_PERF_EN
    logic [perf_width_p-1:0] flits_q [num_in_p];
    logic [perf_width_p-1:0] stall_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            stall_q <= '0;
            for (int j = 0; j < num_in_p; j++) flits_q[j] <= '0;
        end else begin
            if (out_v_o && !out_ready_and_i && stall_q != '1) stall_q <= stall_q + 1'b1;
            for (int j = 0; j < num_in_p; j++) begin
                if (deq[j] && flits_q[j] != '1) flits_q[j] <= flits_q[j] + 1'b1;
            end
        end
    end

    always_comb begin
        perf_stall_o = stall_q;
        for (int j = 0; j < num_in_p; j++) perf_flits_o[j*perf_width_p +: perf_width_p] = flits_q[j];
    end
`else
    assign perf_flits_o = '0;
    assign perf_stall_o = '0;
`endif

endmodule

// File: tb/tb_bp_sac_edge_concentrator.sv
// Randomized scoreboard bench for bp_sac_edge_concentrator. A packet-level model
// (per-row queues, round-robin owner, remaining-flit count) predicts every output
// cycle; input handshakes push into the per-row expected queues.

module tb_bp_sac_edge_concentrator;

    localparam int N  = 4;
    localparam int W  = 64;
    localparam int LW = 4;
    localparam int LO = 0;
    localparam int PW = 32;

    logic            clk = 1'b0;
    logic            reset_i;
    logic [N*W-1:0]  in_data;
    logic [N-1:0]    in_v, in_ready, grant;
    logic [W-1:0]    out_data;
    logic            out_v, out_ready, busy;
    logic [N*PW-1:0] perf_flits;
    logic [PW-1:0]   perf_stall;

    bp_sac_edge_concentrator #(
        .num_in_p     (N),
        .flit_width_p (W),
        .len_width_p  (LW),
        .len_offset_p (LO),
        .perf_width_p (PW)
    ) dut (
        .clk_i           (clk),
        .reset_i         (reset_i),
        .in_data_i       (in_data),
        .in_v_i          (in_v),
        .in_ready_and_o  (in_ready),
        .out_data_o      (out_data),
        .out_v_o         (out_v),
        .out_ready_and_i (out_ready),
        .grant_o         (grant),
        .busy_o          (busy),
        .perf_flits_o    (perf_flits),
        .perf_stall_o    (perf_stall)
    );

    always #5 clk = ~clk;

    logic [W-1:0] send_q [N][$];
    logic [W-1:0] exp_q  [N][$];

    int  m_owner, m_rem, m_ptr, m_stall;
    bit  m_hdr, m_waited;
    int  m_flits [N];
    int  g_cnt [N];
    int  v_pct [N];
    int  r_pct;
    int  cyc, t_in, t_out;
    int  checks, errors;

    logic [N-1:0] exp_rdy, exp_grant;
    logic [W-1:0] popped;
    bit           ev;
    int           idx;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_val);
        checks++;
        if (act !== exp_val) begin
            errors++;
            $display("FAIL %s got %0h expected %0h (cycle %0d)", name, act, exp_val, cyc);
        end
    endtask

    task automatic add_pkt(input int row, input int len);
        logic [W-1:0] f;
        f = {$urandom, $urandom};
        f[LO +: LW] = LW'(len);
        send_q[row].push_back(f);
        for (int k = 0; k < len; k++) send_q[row].push_back({$urandom, $urandom});
    endtask

    function automatic bit pending();
        bit p = (m_owner >= 0);
        for (int j = 0; j < N; j++) if (send_q[j].size() > 0 || exp_q[j].size() > 0) p = 1'b1;
        return p;
    endfunction

    task automatic drain(input int budget);
        int n = 0;
        while (pending() && n < budget) begin
            @(posedge clk);
            n++;
        end
        checks++;
        if (n >= budget) begin
            errors++;
            $display("FAIL drain_timeout got %0d cycles required < %0d", n, budget);
        end
        repeat (2) @(posedge clk);
        #2;
    endtask

    task automatic check_perf();
`ifdef BP_SAC_EDGE_PERF_EN
        for (int j = 0; j < N; j++) chk("perf_flits", 64'(perf_flits[j*PW +: PW]), 64'(m_flits[j]));
        chk("perf_stall", 64'(perf_stall), 64'(m_stall));
`else
        chk("perf_flits_zero", 64'(perf_flits), 64'd0);
        chk("perf_stall_zero", 64'(perf_stall), 64'd0);
`endif
    endtask

    // Monitor / reference model, evaluated mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (reset_i) begin
            chk("rst_out_v", 64'(out_v), 64'd0);
            chk("rst_grant", 64'(grant), 64'd0);
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_in_ready", 64'(in_ready), 64'd0);
            for (int j = 0; j < N; j++) begin
                exp_q[j].delete();
                send_q[j].delete();
                m_flits[j] = 0;
            end
            m_owner = -1; m_ptr = 0; m_rem = 0; m_hdr = 0; m_waited = 0; m_stall = 0;
        end else begin
            for (int j = 0; j < N; j++) exp_rdy[j] = (exp_q[j].size() < 2);
            chk("in_ready", 64'(in_ready), 64'(exp_rdy));
            if (m_owner < 0) begin
                for (int i = 0; i < N; i++) begin
                    idx = (m_ptr + i) % N;
                    if (m_owner < 0 && exp_q[idx].size() > 0) begin
                        m_owner = idx; m_hdr = 1; m_waited = 0;
                    end
                end
            end
            ev = (m_owner >= 0) && (exp_q[m_owner].size() > 0);
            exp_grant = '0;
            if (m_owner >= 0) exp_grant[m_owner] = 1'b1;
            chk("out_v", 64'(out_v), 64'(ev));
            chk("grant", 64'(grant), 64'(exp_grant));
            chk("busy", 64'(busy), 64'((m_owner >= 0) && (!m_hdr || m_waited)));
            if (ev) chk("out_data", out_data, exp_q[m_owner][0]);
            if (out_v && out_ready) begin
                for (int j = 0; j < N; j++) if (grant[j]) g_cnt[j]++;
            end
            if (ev && !out_ready) m_stall++;
            if (ev && out_ready) begin
                if (t_out < 0) t_out = cyc;
                popped = exp_q[m_owner].pop_front();
                m_flits[m_owner]++;
                if (m_hdr) begin
                    m_hdr = 0;
                    m_rem = int'(popped[LO +: LW]);
                end else begin
                    m_rem--;
                end
                if (m_rem == 0) begin
                    m_ptr = (m_owner + 1) % N;
                    m_owner = -1;
                end
            end else if (m_owner >= 0 && m_hdr) begin
                m_waited = 1;
            end
            for (int j = 0; j < N; j++) begin
                if (in_v[j] && exp_rdy[j]) begin
                    exp_q[j].push_back(in_data[j*W +: W]);
                    void'(send_q[j].pop_front());
                    if (t_in < 0) t_in = cyc;
                end
            end
        end
    end

    // Upstream/downstream driver.
    always @(posedge clk) begin
        #1;
        for (int j = 0; j < N; j++) begin
            if (send_q[j].size() > 0 && $urandom_range(99) < v_pct[j]) begin
                in_v[j] = 1'b1;
                in_data[j*W +: W] = send_q[j][0];
            end else begin
                in_v[j] = 1'b0;
                in_data[j*W +: W] = {$urandom, $urandom};
            end
        end
        out_ready = ($urandom_range(99) < r_pct);
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        checks = 0; errors = 0; cyc = 0; t_in = 0; t_out = 0;
        m_owner = -1; m_ptr = 0; m_rem = 0; m_hdr = 0; m_waited = 0; m_stall = 0;
        for (int j = 0; j < N; j++) begin
            v_pct[j] = 100; m_flits[j] = 0; g_cnt[j] = 0;
        end
        r_pct = 100;
        reset_i = 1'b1; in_v = '0; in_data = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_i = 1'b0;
        @(posedge clk); #2;
        check_perf();

        // Single packet on row 2: header + 3 body flits.
        t_in = -1; t_out = -1;
        for (int j = 0; j < N; j++) g_cnt[j] = 0;
        add_pkt(2, 3);
        drain(100);
        chk("first_flit_latency", 64'(t_out - t_in), 64'd1);
        chk("single_pkt_flits", 64'(g_cnt[2]), 64'd4);
        check_perf();

        // Fairness with continuous len=0 traffic on all rows.
        for (int j = 0; j < N; j++) g_cnt[j] = 0;
        for (int k = 0; k < 100; k++) for (int j = 0; j < N; j++) add_pkt(j, 0);
        drain(1000);
        for (int j = 0; j < N; j++) chk("fair_share", 64'(g_cnt[j]), 64'd100);

        // Wormhole lock: row 0 valid is intermittent, row 1 waits behind it.
        v_pct[0] = 40;
        add_pkt(0, 5); add_pkt(1, 0); add_pkt(1, 1); add_pkt(0, 2);
        drain(500);
        v_pct[0] = 100;
        check_perf();

        // Backpressure hold and full FIFO.
        r_pct = 0;
        add_pkt(2, 0);
        repeat (2) @(posedge clk);
        add_pkt(0, 0); add_pkt(1, 2);
        repeat (6) @(posedge clk);
        #2 chk("full_fifo_ready1", 64'(in_ready[1]), 64'd0);
        chk("bp_send_left1", 64'(send_q[1].size()), 64'd1);
        r_pct = 100;
        drain(200);
        check_perf();

        // Reset in BODY with two body flits remaining.
        add_pkt(0, 5);
        n = 0;
        do begin
            @(posedge clk);
            n++;
        end while (!(m_owner == 0 && !m_hdr && m_rem == 2) && n < 200);
        checks++;
        if (n >= 200) begin
            errors++;
            $display("FAIL body_wait got %0d cycles required < 200", n);
        end
        #1 reset_i = 1'b1;
        @(posedge clk);
        #1 reset_i = 1'b0;
        #1;
        chk("post_rst_out_v", 64'(out_v), 64'd0);
        chk("post_rst_busy", 64'(busy), 64'd0);
        chk("post_rst_grant", 64'(grant), 64'd0);
        add_pkt(3, 0);
        drain(100);
        check_perf();

        // Random traffic.
        r_pct = 70;
        for (int j = 0; j < N; j++) v_pct[j] = 30 + $urandom_range(70);
        for (int c = 0; c < 2000; c++) begin
            @(posedge clk);
            for (int j = 0; j < N; j++) begin
                if (send_q[j].size() < 8 && $urandom_range(9) == 0) add_pkt(j, $urandom_range(15));
            end
            if (c % 500 == 499) r_pct = 20 + $urandom_range(80);
        end
        r_pct = 100;
        for (int j = 0; j < N; j++) v_pct[j] = 100;
        drain(3000);
        check_perf();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/bp_sac_edge_concentrator.md
Name: bp_sac_edge_concentrator

Overview:
- Wormhole-aware N:1 concentrator at the east edge of the streaming accelerator complex.
- Merges the per-row coherence request links of num_in_p accelerator rows onto one edge link toward the coherence network.
- Each input has 2-entry buffering. Round-robin packet-level arbitration holds the grant until a packet's last flit has been sent.
- Replaces fixed per-row edge wiring so the complex can scale its row count independently of the edge channel count.

Parameters:
- num_in_p, 4, number of input row links (≥2).
- flit_width_p, 64, flit width in bits.
- len_width_p, 4, width of the header length field.
- len_offset_p, 0, bit position of the length field LSB within the header flit.
- perf_width_p, 32, width of each performance counter.

Ports:
- clk_i  in  1  clock.
- reset_i  in  1  synchronous, active-high reset.
- in_data_i  in  num_in_p*flit_width_p  input flits; row j occupies slice [j*flit_width_p +: flit_width_p].
- in_v_i  in  num_in_p  per-input valid.
- in_ready_and_o  out  num_in_p  per-input ready (ready-and handshake).
- out_data_o  out  flit_width_p  concentrated flit.
- out_v_o  out  1  output valid.
- out_ready_and_i  in  1  downstream ready.
- grant_o  out  num_in_p  one-hot current owner; zero when no input is owned.
- busy_o  out  1  high in PEND or BODY state.
- perf_flits_o  out  num_in_p*perf_width_p  per-input count of forwarded flits.
- perf_stall_o  out  perf_width_p  count of cycles with out_v_o=1 and out_ready_and_i=0.

Behaviour:
- Clock and reset: one clock, clk_i; reset_i is synchronous and active-high.
- Reset values:
  - out_v_o=0, grant_o=0, busy_o=0, in_ready_and_o=0 while reset_i is high.
  - All input FIFOs are empty.
  - Round-robin priority pointer = 0. State = IDLE. Performance counters = 0.
- Reset mid-packet discards all buffered flits and returns to IDLE. Recovery is the upstream's responsibility.
- Input buffers:
  - One 2-entry FIFO per input; in_ready_and_o[j] = ~full_j.
  - Input handshake: in_v_i[j] & in_ready_and_o[j].
  - Enqueue and dequeue in the same cycle are allowed when the FIFO holds 1 entry.
  - Minimum latency from input handshake to out_v_o is 1 cycle. Sustained throughput is 1 flit/cycle.
- Header: the first flit of each packet. len = header[len_offset_p +: len_width_p] = number of body flits that follow (0 to 2^len_width_p-1).
- State machine. The selected input is sel; its FIFO head drives out_data_o, and out_v_o = head valid of sel.
  - IDLE:
    - If no FIFO head is valid: out_v_o=0, grant_o=0.
    - Otherwise sel = first valid input at or after the pointer, in modulo order. grant_o is one-hot on sel, combinationally.
    - Handshake with len=0: stay in IDLE; pointer = sel+1 mod num_in_p.
    - Handshake with len>0: go to BODY; cnt = len; sel is registered.
    - No handshake: go to PEND; sel is registered.
  - PEND:
    - The registered sel is presented. out_v_o and out_data_o stay stable until handshake; no re-arbitration.
    - On handshake, the same transitions as IDLE apply.
  - BODY:
    - sel's FIFO is presented. Each handshake decrements cnt.
    - Handshake with cnt==1: go to IDLE; pointer = sel+1 mod num_in_p.
    - An empty sel FIFO gives out_v_o=0 (bubble). Other inputs are never granted mid-packet.
- Only sel's FIFO dequeues. Dequeue = out_v_o & out_ready_and_i.
- cnt is len_width_p bits wide and never underflows.

Optional Feature:
- Macro: BP_SAC_EDGE_PERF_EN.
- Defined:
  - perf_flits_o[j] increments on each output handshake while sel==j.
  - perf_stall_o increments on each stall cycle.
  - Counters saturate at all-ones and clear on reset.
- Undefined: perf_flits_o and perf_stall_o are tied to 0 and no counter flops are built. Concentrator behaviour is identical.

Test Plan:
- Single packet: input 2 sends a header with len=3 plus 3 body flits; out_ready_and_i=1 throughout → 4 output flits on consecutive cycles starting 1 cycle after the first input handshake; grant_o=4'b0100 throughout; pointer=3 afterwards.
- Fairness: all 4 inputs continuously offer len=0 packets → output order is 0,1,2,3,0,1… and each input receives exactly 25% of 400 flits.
- Wormhole lock: input 0 sends len=5 and stalls its valid for 3 cycles after the 2nd body flit while input 1 is valid → out_v_o=0 for 3 cycles; no input-1 flit appears until input 0's 6th flit has handshaken.
- Backpressure hold: header presented with out_ready_and_i=0 for 4 cycles while a higher-priority input becomes valid → out_data_o stable, grant_o unchanged, state PEND; perf_stall_o=4 with the macro defined, 0 without.
- Full FIFO: out_ready_and_i=0; input 1 drives 3 flits → in_ready_and_o[1] falls after 2 accepts; the 3rd flit is accepted only after out_ready_and_i rises.
- Reset mid-packet: reset_i asserted 1 cycle during BODY with cnt=2 → next cycle out_v_o=0, busy_o=0, grant_o=0; a new len=0 header on input 3 is forwarded with the pointer starting at 0.
